hs_arbiter_m: RTL



---
 rtl/hs_arbiter_m.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/hs_arbiter_m.sv
// hs_arbiter_m
// Round-robin arbiter sharing one 4-phase req/ack channel between N_REQ
// synchronous requesters. The shared channel drives an asynchronous pipeline
// stage. Each handshake is relayed end to end. A stalled stage is flagged by
// a timeout, and the arbiter recovers from it cleanly.
//
// Ports
//   clk           in   clock
//   reset         in   asynchronous, active-high reset
//   req_in        in   per-requester 4-phase request (synchronous to clk)
//   ack_out       out  per-requester 4-phase acknowledge, at most one bit high
//   right_req_out out  request to the async stage
//   right_ack_in  in   acknowledge from the async stage (asynchronous)
//   grant_id      out  index of the current owner, valid while busy
//   busy          out  high whenever the FSM is not idle
//   timeout_err   out  sticky timeout flag
//   err_clr       in   pulse: clears timeout_err, and leaves ERR once the ack is low
module hs_arbiter_m #(
  parameter int N_REQ       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_in,
  output logic [N_REQ-1:0]         ack_out,
  output logic                     right_req_out,
  input  logic                     right_ack_in,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     timeout_err,
  input  logic                     err_clr
);

  localparam int IDX_W = $clog2(N_REQ);
  // A disabled timeout (TIMEOUT=0) still gets a 1-bit counter.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  // The counter value seen on the edge that fires the timeout. Firing one
  // count early puts the error exactly TIMEOUT cycles after state entry.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FWD_UP   = 3'd1,
    ST_WAIT_RLS = 3'd2,
    ST_FWD_DN   = 3'd3,
    ST_ERR      = 3'd4
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [IDX_W-1:0]       r_ptr;
  logic [IDX_W-1:0]       r_grant;
  logic [CNT_W-1:0]       r_cnt;
  logic [N_REQ-1:0]       r_ack;
  logic                   r_rreq;
  logic                   r_busy;
  logic                   r_timeout_err;

  logic                   w_ack_s;
  logic                   w_any;
  logic [IDX_W-1:0]       w_win;
  logic                   w_own_req;
  logic                   w_to_hit;

  // Returns (base + off) mod N_REQ, where off < N_REQ.
  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end else begin
      sum = sum;
    end
    return IDX_W'(sum);
  endfunction

  // Returns the requester after g, wrapping N_REQ-1 back to 0.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] g);
    if (g == IDX_W'(N_REQ - 1)) begin
      return {IDX_W{1'b0}};
    end else begin
      return g + IDX_W'(1);
    end
  endfunction

  assign w_ack_s   = r_sync[SYNC_STAGES-1];
  assign w_own_req = req_in[r_grant];
  assign w_to_hit  = TO_EN && (r_cnt >= CNT_LAST);

  // Synchronize the asynchronous acknowledge from the stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], right_ack_in};
    end
  end

  // Round-robin search. Scanning from the far end lets the entry nearest
  // the pointer win.
  always_comb begin
    w_any = |req_in;
    w_win = {IDX_W{1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_in[rr_index(r_ptr, i)]) begin
        w_win = rr_index(r_ptr, i);
      end else begin
        w_win = w_win;
      end
    end
  end

  // Handshake FSM with registered outputs and timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_ptr         <= {IDX_W{1'b0}};
      r_grant       <= {IDX_W{1'b0}};
      r_cnt         <= {CNT_W{1'b0}};
      r_ack         <= {N_REQ{1'b0}};
      r_rreq        <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      // A timeout in the same cycle overrides this clear.
      if (err_clr) begin
        r_timeout_err <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_win;
            r_rreq  <= 1'b1;
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b1;
            r_state <= ST_FWD_UP;
          end
        end
        ST_FWD_UP: begin
          if (w_ack_s) begin
            r_ack   <= N_REQ'(1) << r_grant;
            r_state <= ST_WAIT_RLS;
          end else if (w_to_hit) begin
            r_timeout_err <= 1'b1;
            r_rreq        <= 1'b0;
            r_ack         <= {N_REQ{1'b0}};
            r_state       <= ST_ERR;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_RLS: begin
          // An owner that dropped its request early leaves here at once.
          if (!w_own_req) begin
            r_rreq  <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
            r_state <= ST_FWD_DN;
          end
        end
        ST_FWD_DN: begin
          if (!w_ack_s) begin
            r_ack   <= {N_REQ{1'b0}};
            r_ptr   <= rr_next(r_grant);
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_to_hit) begin
            r_timeout_err <= 1'b1;
            r_rreq        <= 1'b0;
            r_ack         <= {N_REQ{1'b0}};
            r_state       <= ST_ERR;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_ERR: begin
          // Skip past the stalled owner so that it cannot starve the others.
          if (err_clr && !w_ack_s) begin
            r_ptr   <= rr_next(r_grant);
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_rreq  <= 1'b0;
          r_ack   <= {N_REQ{1'b0}};
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack_out       = r_ack;
  assign right_req_out = r_rreq;
  assign grant_id      = r_grant;
  assign busy          = r_busy;
  assign timeout_err   = r_timeout_err;

endmodule
